prbs32_rx_checker: RTL and testbench

//  Receive-side partner of the 32-bit PRBS/LFSR stream generator. Takes the generator's serial bit stream,

---
 rtl/prbs32_rx_checker.sv | 152 +++++++++++++++
 tb/tb_prbs32_rx_checker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/prbs32_rx_checker.sv
// Self-synchronising checker for the x^32+x^30+x^26+x^25 PRBS stream: searches, locks, counts errors.
// Optional `PRBS_CHK_BITCNT_EN adds a saturating bit_count of bits checked while locked.
module prbs32_rx_checker #(
    parameter int unsigned LOCK_THRESH = 16,
    parameter int unsigned LOSS_THRESH = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
`ifdef PRBS_CHK_BITCNT_EN
    ,
    output logic [31:0]      bit_count
`endif
);

    typedef enum logic {StSearch, StLocked} state_e;

    localparam logic [7:0] LockThr = 8'(LOCK_THRESH);
    localparam logic [3:0] LossThr = 4'(LOSS_THRESH);

    state_e           state_q, state_d;
    logic [31:0]      hist_q, hist_d;
    logic [5:0]       fill_q, fill_d;
    logic [7:0]       match_q, match_d;
    logic [3:0]       bad_q, bad_d;
    logic [5:0]       good_q, good_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             pred;
    logic             mismatch;
    logic             count_err;

    // An all-zero history would otherwise predict zeros forever; force a 1 to escape it.
    assign pred     = (hist_q[31] ^ hist_q[29] ^ hist_q[25] ^ hist_q[24]) | (hist_q == 32'd0);
    assign mismatch = din ^ pred;

    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        match_d     = match_q;
        bad_d       = bad_q;
        good_d      = good_q;
        err_pulse_d = 1'b0;
        count_err   = 1'b0;
        if (din_valid) begin
            unique case (state_q)
                StSearch: begin
                    hist_d = {hist_q[30:0], din};
                    if (fill_q < 6'd32) begin
                        fill_d = fill_q + 6'd1;
                    end else if (mismatch) begin
                        match_d = 8'd0;
                    end else if (match_q + 8'd1 == LockThr) begin
                        state_d = StLocked;
                        match_d = 8'd0;
                        bad_d   = 4'd0;
                        good_d  = 6'd0;
                    end else begin
                        match_d = match_q + 8'd1;
                    end
                end
                StLocked: begin
                    // Feed back the prediction so a received error never corrupts the history.
                    hist_d = {hist_q[30:0], pred};
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        count_err   = 1'b1;
                        good_d      = 6'd0;
                        if (bad_q + 4'd1 == LossThr) begin
                            state_d = StSearch;
                            fill_d  = 6'd0;
                            match_d = 8'd0;
                            bad_d   = 4'd0;
                        end else begin
                            bad_d = bad_q + 4'd1;
                        end
                    end else if (good_q >= 6'd31) begin
                        good_d = 6'd32;
                        bad_d  = 4'd0;
                    end else begin
                        good_d = good_q + 6'd1;
                    end
                end
                default: state_d = StSearch;
            endcase
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (count_err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

`ifdef PRBS_CHK_BITCNT_EN
    logic [31:0] bit_cnt_q, bit_cnt_d;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (err_clr) begin
            bit_cnt_d = 32'd0;
        end else if (din_valid && (state_q == StLocked) && (bit_cnt_q != 32'hFFFF_FFFF)) begin
            bit_cnt_d = bit_cnt_q + 32'd1;
        end
    end

    assign bit_count = bit_cnt_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StSearch;
            hist_q      <= 32'd0;
            fill_q      <= 6'd0;
            match_q     <= 8'd0;
            bad_q       <= 4'd0;
            good_q      <= 6'd0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
`ifdef PRBS_CHK_BITCNT_EN
            bit_cnt_q   <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            bad_q       <= bad_d;
            good_q      <= good_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
`ifdef PRBS_CHK_BITCNT_EN
            bit_cnt_q   <= bit_cnt_d;
`endif
        end
    end

    assign locked    = (state_q == StLocked);
    assign err_pulse = err_pulse_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_prbs32_rx_checker.sv
// Directed bench for prbs32_rx_checker: lock, errors, loss/relock, gaps, err_clr, saturation, reset.
module tb_prbs32_rx_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic        err_clr = 1'b0;
    logic        locked_a, err_pulse_a;
    logic [15:0] err_count_a;
    logic        locked_b, err_pulse_b;
    logic [3:0]  err_count_b;
`ifdef PRBS_CHK_BITCNT_EN
    logic [31:0] bit_count_a, bit_count_b;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    int          pulses = 0;
    logic        seen_locked = 1'b0;
    logic [31:0] gen = 32'h1;

    prbs32_rx_checker u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .err_clr   (err_clr),
        .locked    (locked_a),
        .err_pulse (err_pulse_a),
        .err_count (err_count_a)
`ifdef PRBS_CHK_BITCNT_EN
        ,.bit_count (bit_count_a)
`endif
    );

    prbs32_rx_checker #(
        .CNT_W (4)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .err_clr   (err_clr),
        .locked    (locked_b),
        .err_pulse (err_pulse_b),
        .err_count (err_count_b)
`ifdef PRBS_CHK_BITCNT_EN
        ,.bit_count (bit_count_b)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic gen_bit(output logic b);
        b   = (gen[31] ^ gen[29] ^ gen[25] ^ gen[24]) | (gen == 32'd0);
        gen = {gen[30:0], b};
    endtask

    task automatic step(input logic b, input logic v, input logic clr);
        din       = b;
        din_valid = v;
        err_clr   = clr;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        if (err_pulse_a) pulses++;
        if (locked_a) seen_locked = 1'b1;
    endtask

    task automatic clean(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            gen_bit(b);
            step(b, 1'b1, 1'b0);
        end
    endtask

    task automatic flip();
        logic b;
        gen_bit(b);
        step(~b, 1'b1, 1'b0);
    endtask

    task automatic err_group();
        flip(); clean(1); flip(); clean(1); flip(); clean(33);
    endtask

    // Returns valid-bit count at which locked first reads high, 0 if it never does.
    task automatic lock_search(input logic gaps, output int at);
        at = 0;
        for (int i = 1; i <= 200 && at == 0; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) step(1'($urandom), 1'b0, 1'b0);
            end
            clean(1);
            if (locked_a) at = i;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        gen = 32'h1;
        pulses = 0;
        seen_locked = 1'b0;
    endtask

    initial begin
        int   at;
        logic b;

        #1;
        check_eq("rst_locked", 32'(locked_a), 32'd0);
        check_eq("rst_err_pulse", 32'(err_pulse_a), 32'd0);
        check_eq("rst_err_count", 32'(err_count_a), 32'd0);
        do_reset();
        for (int i = 0; i < 20; i++) step(1'($urandom), 1'b0, 1'b0);
        check_eq("idle_no_lock", 32'(seen_locked), 32'd0);

        // Clean lock and long clean run
        lock_search(1'b0, at);
        check_eq("clean_lock_at", at, 32'd48);
        clean(9952);
        check_eq("clean_err_count", 32'(err_count_a), 32'd0);
        check_eq("clean_locked", 32'(locked_a), 32'd1);
        check_eq("clean_pulses", pulses, 32'd0);
`ifdef PRBS_CHK_BITCNT_EN
        check_eq("clean_bit_count", bit_count_a, 32'd9952);
`endif

        // Single flipped bit
        flip();
        check_eq("flip_pulse", 32'(err_pulse_a), 32'd1);
        check_eq("flip_count", 32'(err_count_a), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        check_eq("pulse_drop_invalid", 32'(err_pulse_a), 32'd0);
        clean(100);
        check_eq("flip_pulses_total", pulses, 32'd1);
        check_eq("flip_count_hold", 32'(err_count_a), 32'd1);
        check_eq("flip_still_locked", 32'(locked_a), 32'd1);

        // Loss of lock after 4 spaced errors, then relock
        step(1'b0, 1'b0, 1'b1);
        check_eq("clr_count", 32'(err_count_a), 32'd0);
`ifdef PRBS_CHK_BITCNT_EN
        check_eq("clr_bit_count", bit_count_a, 32'd0);
`endif
        flip(); clean(4); flip(); clean(4); flip();
        check_eq("loss_still_locked", 32'(locked_a), 32'd1);
        clean(4); flip();
        check_eq("loss_unlocked", 32'(locked_a), 32'd0);
        check_eq("loss_count_a", 32'(err_count_a), 32'd4);
        check_eq("loss_count_b", 32'(err_count_b), 32'd4);
        lock_search(1'b0, at);
        check_eq("relock_at", at, 32'd48);

        // err_clr colliding with a counted mismatch
        step(1'b0, 1'b0, 1'b1);
        err_group(); err_group(); flip(); clean(33);
        check_eq("seven_count", 32'(err_count_a), 32'd7);
        gen_bit(b);
        step(~b, 1'b1, 1'b1);
        check_eq("clr_vs_err_count", 32'(err_count_a), 32'd0);
        check_eq("clr_vs_err_pulse", 32'(err_pulse_a), 32'd1);
        clean(33);

        // Saturation on the 4-bit instance
        for (int g = 0; g < 6; g++) err_group();
        check_eq("sat_count_a", 32'(err_count_a), 32'd18);
        check_eq("sat_count_b", 32'(err_count_b), 32'd15);
        check_eq("sat_locked", 32'(locked_a), 32'd1);

        // Asynchronous reset while locked
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("async_rst_locked", 32'(locked_a), 32'd0);
        check_eq("async_rst_count", 32'(err_count_a), 32'd0);
        check_eq("async_rst_pulse", 32'(err_pulse_a), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        gen = 32'h1;

        // Reset mid-fill restarts the fill
        clean(20);
        do_reset();
        lock_search(1'b0, at);
        check_eq("midfill_relock_at", at, 32'd48);

        // Gaps in din_valid do not move the lock point
        do_reset();
        lock_search(1'b1, at);
        check_eq("gap_lock_at", at, 32'd48);

        // All-zero input never locks
        do_reset();
        for (int i = 0; i < 1000; i++) step(1'b0, 1'b1, 1'b0);
        check_eq("zeros_no_lock", 32'(seen_locked), 32'd0);
        check_eq("zeros_no_pulse", pulses, 32'd0);
        check_eq("zeros_count", 32'(err_count_a), 32'd0);

        // Inverted stream never locks
        do_reset();
        for (int i = 0; i < 300; i++) begin
            gen_bit(b);
            step(~b, 1'b1, 1'b0);
        end
        check_eq("inv_no_lock", 32'(seen_locked), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
